// File: rtl/semiauto_motion_ctrl.sv
// Registered motion stage for semi-auto driving: state capture, turn timing, motor decode.
// Optional SEMIAUTO_AROUND_EN: `around` selects AROUND_TICKS for U-turns.
module semiauto_motion_ctrl #(
    parameter int unsigned TICK_DIV     = 2_000_000,
    parameter int unsigned TURN_TICKS   = 45,
    parameter int unsigned AROUND_TICKS = 90
) (
    input  logic       sys_clk,
    input  logic       rst_n,
    input  logic       power,
    input  logic [1:0] global_state,
    input  logic [1:0] next_state,
    input  logic [3:0] next_moving_state,
    input  logic       around,
    output logic [1:0] state,
    output logic [3:0] moving_state,
    output logic       turn_done,
    output logic       left_fwd,
    output logic       left_bwd,
    output logic       right_fwd,
    output logic       right_bwd
);
    localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    localparam logic [1:0] S2 = 2'b01;
    localparam logic [1:0] S3 = 2'b10;

    localparam logic [3:0] MV_STOP  = 4'b0000;
    localparam logic [3:0] MV_FWD   = 4'b0001;
    localparam logic [3:0] MV_LEFT  = 4'b0100;
    localparam logic [3:0] MV_RIGHT = 4'b1000;

    localparam logic [10:0]   TURN_LIM = 11'(TURN_TICKS);
    localparam logic [PW-1:0] TICK_MAX = PW'(TICK_DIV - 1);

    logic          run_q;
    logic [PW-1:0] presc;
    logic [10:0]   turn_cnt;
    logic [10:0]   limit;
    logic          active;
    logic          tick;
    logic          turn_end;
    logic          legal_turn;

`ifdef SEMIAUTO_AROUND_EN
    localparam logic [10:0] AROUND_LIM = 11'(AROUND_TICKS);
    logic [10:0] limit_q;
    assign limit = limit_q;
`else
    localparam int unsigned unused_around_ticks = AROUND_TICKS;
    logic unused_around;
    assign unused_around = around;
    assign limit = TURN_LIM;
`endif

    // Releases one edge after rst_n rises so the first capture lands on the second edge.
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) run_q <= 1'b0;
        else        run_q <= 1'b1;
    end

    assign active     = power && (global_state == 2'b01 || global_state == 2'b10);
    assign tick       = (presc == TICK_MAX);
    assign turn_end   = tick && (turn_cnt == limit - 11'd1);
    assign legal_turn = (next_moving_state == MV_LEFT) || (next_moving_state == MV_RIGHT);

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S2;
            moving_state <= MV_STOP;
            turn_done    <= 1'b0;
            presc        <= '0;
            turn_cnt     <= '0;
`ifdef SEMIAUTO_AROUND_EN
            limit_q      <= TURN_LIM;
`endif
        end else if (run_q) begin
            turn_done <= 1'b0;
            if (!active) begin
                state        <= S2;
                moving_state <= MV_STOP;
                presc        <= '0;
                turn_cnt     <= '0;
            end else if (state == S3) begin
                if (turn_end) begin
                    state        <= S2;
                    moving_state <= MV_STOP;
                    turn_done    <= 1'b1;
                    presc        <= '0;
                    turn_cnt     <= '0;
                end else begin
                    presc <= tick ? '0 : presc + PW'(1);
                    if (tick) turn_cnt <= turn_cnt + 11'd1;
                end
            end else if (next_state == S3) begin
                if (legal_turn) begin
                    state        <= S3;
                    moving_state <= next_moving_state;
                    presc        <= '0;
                    turn_cnt     <= '0;
`ifdef SEMIAUTO_AROUND_EN
                    limit_q      <= around ? AROUND_LIM : TURN_LIM;
`endif
                end else begin
                    state        <= S2;
                    moving_state <= MV_STOP;
                end
            end else begin
                state        <= next_state;
                moving_state <= next_moving_state;
            end
        end
    end

    always_comb begin
        left_fwd  = 1'b0;
        left_bwd  = 1'b0;
        right_fwd = 1'b0;
        right_bwd = 1'b0;
        case (moving_state)
            MV_FWD: begin
                left_fwd  = 1'b1;
                right_fwd = 1'b1;
            end
            MV_LEFT: begin
                left_bwd  = 1'b1;
                right_fwd = 1'b1;
            end
            MV_RIGHT: begin
                left_fwd  = 1'b1;
                right_bwd = 1'b1;
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_semiauto_motion_ctrl.sv
// Self-checking bench for semiauto_motion_ctrl: directed scenarios plus random traffic
// compared cycle by cycle against a behavioural model.
module tb_semiauto_motion_ctrl;
    localparam int TD = 4;
    localparam int TT = 3;
    localparam int AT = 6;
`ifdef SEMIAUTO_AROUND_EN
    localparam bit AroundEn = 1'b1;
`else
    localparam bit AroundEn = 1'b0;
`endif

    logic       sys_clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       power, around;
    logic [1:0] global_state, next_state;
    logic [3:0] next_moving_state;
    logic [1:0] state;
    logic [3:0] moving_state;
    logic       turn_done, left_fwd, left_bwd, right_fwd, right_bwd;

    int checks = 0;
    int errors = 0;

    // Behavioural model: turns are a countdown of remaining cycles.
    logic [1:0] m_state;
    logic [3:0] m_mov;
    logic       m_done;
    logic       m_run;
    int         m_rem;

    semiauto_motion_ctrl #(
        .TICK_DIV    (TD),
        .TURN_TICKS  (TT),
        .AROUND_TICKS(AT)
    ) dut (
        .sys_clk          (sys_clk),
        .rst_n            (rst_n),
        .power            (power),
        .global_state     (global_state),
        .next_state       (next_state),
        .next_moving_state(next_moving_state),
        .around           (around),
        .state            (state),
        .moving_state     (moving_state),
        .turn_done        (turn_done),
        .left_fwd         (left_fwd),
        .left_bwd         (left_bwd),
        .right_fwd        (right_fwd),
        .right_bwd        (right_bwd)
    );

    always #5 sys_clk = ~sys_clk;

    // {left_fwd, left_bwd, right_fwd, right_bwd}
    function automatic logic [3:0] motors(input logic [3:0] mv);
        case (mv)
            4'b0001: return 4'b1010;
            4'b0100: return 4'b0110;
            4'b1000: return 4'b1001;
            default: return 4'b0000;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_step();
        bit act;
        act = power && (global_state == 2'd1 || global_state == 2'd2);
        m_done = 1'b0;
        if (!m_run) begin
            m_run = 1'b1;
        end else if (!act) begin
            m_state = 2'd1;
            m_mov   = 4'd0;
            m_rem   = 0;
        end else if (m_state == 2'd2) begin
            m_rem--;
            if (m_rem == 0) begin
                m_state = 2'd1;
                m_mov   = 4'd0;
                m_done  = 1'b1;
            end
        end else if (next_state == 2'd2) begin
            if (next_moving_state == 4'b0100 || next_moving_state == 4'b1000) begin
                m_state = 2'd2;
                m_mov   = next_moving_state;
                m_rem   = ((AroundEn && around) ? AT : TT) * TD;
            end else begin
                m_state = 2'd1;
                m_mov   = 4'd0;
            end
        end else begin
            m_state = next_state;
            m_mov   = next_moving_state;
        end
    endtask

    task automatic cyc();
        @(posedge sys_clk);
        if (rst_n) model_step();
        @(negedge sys_clk);
        check("state", 32'(state), 32'(m_state));
        check("moving_state", 32'(moving_state), 32'(m_mov));
        check("turn_done", 32'(turn_done), 32'(m_done));
        check("motors", 32'({left_fwd, left_bwd, right_fwd, right_bwd}), 32'(motors(m_mov)));
    endtask

    task automatic turn_run(input logic [3:0] code, input logic ar, output int dur,
                            output int dones);
        next_state = 2'd1; next_moving_state = 4'd0; cyc();
        next_state = 2'd2; next_moving_state = code; around = ar; cyc();
        dur   = (state == 2'd2) ? 1 : 0;
        dones = 0;
        next_state = 2'd0; next_moving_state = 4'd1; around = ~ar;
        repeat (40) begin
            cyc();
            if (state == 2'd2) dur++;
            if (turn_done) dones++;
        end
    endtask

    initial begin
        int dur, dones, r;
        m_state = 2'd1; m_mov = 4'd0; m_done = 1'b0; m_run = 1'b0; m_rem = 0;
        power = 1'b1; global_state = 2'd1; around = 1'b0;
        next_state = 2'd0; next_moving_state = 4'd0;

        // Reset with arbitrary inputs
        repeat (3) begin
            next_state = 2'($urandom); next_moving_state = 4'($urandom);
            around = 1'($urandom);
            cyc();
        end
        check("reset_state", 32'(state), 32'd1);

        // Release, synchroniser delay, then pass-through
        rst_n = 1'b1; next_state = 2'd0; next_moving_state = 4'd1; around = 1'b0;
        cyc();
        check("sync_hold", 32'(state), 32'd1);
        cyc();
        check("pass_state", 32'(state), 32'd0);
        check("pass_fwd", 32'({left_fwd, right_fwd}), 32'd3);

        turn_run(4'b0100, 1'b0, dur, dones);
        check("left_dur", 32'(dur), 32'(TT * TD));
        check("left_done", 32'(dones), 32'd1);

        turn_run(4'b1000, 1'b1, dur, dones);
        check("uturn_dur", 32'(dur), 32'((AroundEn ? AT : TT) * TD));
        check("uturn_done", 32'(dones), 32'd1);

        // Illegal S3 entry
        next_state = 2'd1; next_moving_state = 4'd0; cyc();
        next_state = 2'd2; next_moving_state = 4'd1; cyc();
        check("illegal_state", 32'(state), 32'd1);
        check("illegal_mov", 32'(moving_state), 32'd0);
        next_state = 2'd1; next_moving_state = 4'd0;
        repeat (3) cyc();

        // Abort five cycles into a turn
        next_state = 2'd2; next_moving_state = 4'b0100; cyc();
        next_state = 2'd1; next_moving_state = 4'd0;
        repeat (4) cyc();
        power = 1'b0; dones = 0;
        cyc();
        check("abort_state", 32'(state), 32'd1);
        check("abort_mov", 32'(moving_state), 32'd0);
        power = 1'b1;
        repeat (TT * TD) begin
            cyc();
            if (turn_done) dones++;
        end
        check("abort_no_done", 32'(dones), 32'd0);
        turn_run(4'b0100, 1'b0, dur, dones);
        check("repower_dur", 32'(dur), 32'(TT * TD));

        // Back-to-back turns: re-entry right after turn_done
        next_state = 2'd2; next_moving_state = 4'b1000; around = 1'b0; dones = 0;
        repeat (30) begin
            cyc();
            if (turn_done) dones++;
        end
        check("b2b_dones", 32'(dones), 32'd2);

        // Random traffic
        repeat (3000) begin
            power        = ($urandom_range(0, 31) != 0);
            global_state = ($urandom_range(0, 15) == 0) ? 2'($urandom) : 2'd1;
            next_state   = 2'($urandom);
            r = $urandom_range(0, 4);
            next_moving_state = (r == 0) ? 4'd0 : (r == 1) ? 4'd1 : (r == 2) ? 4'b0100 :
                                (r == 3) ? 4'b1000 : 4'($urandom);
            around = 1'($urandom);
            cyc();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
